// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per operation.
// Latency: N+2 cycles from the accepted start edge to the done pulse.
// Backpressure: start is only accepted in IDLE; start during an operation is ignored.
module booth_mul_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic           valid,
  output logic [2*N-1:0] Y
);

  localparam int W     = N + 1;
  localparam int CNT_W = $clog2(N + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state;
  logic [W-1:0]       acc;
  logic [W-1:0]       m;
  logic [W-1:0]       q;
  logic               q_m1;
  logic [CNT_W-1:0]   cnt;

  logic [W:0]         acc_x;
  logic [W:0]         m_x;
  logic [W:0]         sum;

  // One guard bit on the add/sub so the pre-shift value never wraps.
  assign acc_x = {acc[W-1], acc};
  assign m_x   = {m[W-1], m};

  always_comb begin
    sum = acc_x;
    case ({q[0], q_m1})
      2'b01:   sum = acc_x + m_x;
      2'b10:   sum = acc_x - m_x;
      default: sum = acc_x;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      acc   <= '0;
      m     <= '0;
      q     <= '0;
      q_m1  <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      valid <= 1'b0;
      Y     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Zero-extending unsigned operands lets one signed Booth datapath serve both modes.
            m     <= {signed_mode & A[N-1], A};
            q     <= {signed_mode & B[N-1], B};
            acc   <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            valid <= 1'b0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc  <= sum[W:1];
          q    <= {sum[0], q[W-1:1]};
          q_m1 <= q[0];
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(N)) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // The 2W-bit product always fits in its low 2N bits.
          Y     <= {acc[N-2:0], q};
          done  <= 1'b1;
          valid <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq at N=8 and N=4 against an arithmetic reference.
module tb_booth_mul_seq;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  logic        rst8, start8, sm8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, valid8;
  logic [15:0] y8;

  logic        rst4, start4, sm4;
  logic [3:0]  a4, b4;
  logic        busy4, done4, valid4;
  logic [7:0]  y4;

  booth_mul_seq #(.N(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .signed_mode(sm8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .valid(valid8), .Y(y8)
  );

  booth_mul_seq #(.N(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .signed_mode(sm4), .A(a4), .B(b4),
    .busy(busy4), .done(done4), .valid(valid4), .Y(y4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Plain integer multiply of the operands interpreted per mode, truncated to 2n bits.
  function automatic longint ref_mul(int n, bit s, longint a, longint b);
    longint av = a;
    longint bv = b;
    if (s && av >= (longint'(1) << (n - 1))) av -= longint'(1) << n;
    if (s && bv >= (longint'(1) << (n - 1))) bv -= longint'(1) << n;
    return (av * bv) & ((longint'(1) << (2 * n)) - 1);
  endfunction

  task automatic wait_done8(output int t, output int gaps);
    t = -1000;
    gaps = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done8) begin
        t = cyc;
        return;
      end
      if (!busy8) gaps++;
    end
  endtask

  task automatic op8(input bit s, input logic [7:0] a, input logic [7:0] b,
                     output logic [15:0] y, output int lat);
    int t0, t1, gaps;
    @(negedge clk); sm8 = s; a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1; t0 = cyc;
    check("busy_on_start8", busy8, 1);
    check("valid_drop8", valid8, 0);
    @(negedge clk); start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
    wait_done8(t1, gaps);
    lat = t1 - t0;
    y = y8;
    check("busy_gap8", gaps, 0);
    check("busy_at_done8", busy8, 0);
    check("valid_at_done8", valid8, 1);
    @(posedge clk); #1;
    check("done_pulse8", done8, 0);
    check("valid_hold8", valid8, 1);
  endtask

  task automatic op4(input bit s, input logic [3:0] a, input logic [3:0] b,
                     output logic [7:0] y, output int lat);
    int t0;
    @(negedge clk); sm4 = s; a4 = a; b4 = b; start4 = 1'b1;
    @(posedge clk); #1; t0 = cyc;
    @(negedge clk); start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'($urandom);
    lat = -1000;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done4) begin
        lat = cyc - t0;
        break;
      end
    end
    y = y4;
  endtask

  initial begin
    logic [15:0] y;
    logic [7:0]  yy;
    int          lat, t0, t1, t2, gaps;
    logic [7:0]  ra, rb;
    bit          rs;

    rst8 = 1'b0; start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    rst4 = 1'b0; start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
    #23;
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_valid8", valid8, 0);
    check("rst_y8", y8, 0);
    check("rst_busy4", busy4, 0);
    check("rst_y4", y4, 0);
    @(negedge clk); rst8 = 1'b1; rst4 = 1'b1;

    op8(1'b1, 8'h03, 8'hFB, y, lat);
    check("s3xm5_y", y, 16'hFFF1);
    check("s3xm5_lat", lat, 10);
    op8(1'b0, 8'hFF, 8'hFF, y, lat);
    check("uffxff_y", y, 16'hFE01);
    op8(1'b1, 8'hFF, 8'hFF, y, lat);
    check("sffxff_y", y, 16'h0001);
    op8(1'b1, 8'h80, 8'h80, y, lat);
    check("s80x80_y", y, 16'h4000);
    op8(1'b1, 8'h80, 8'h7F, y, lat);
    check("s80x7f_y", y, 16'hC080);
    check("s80x7f_lat", lat, 10);

    // Start re-raised mid-run with new operands, then held for back-to-back.
    @(negedge clk); sm8 = 1'b0; a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    @(posedge clk); #1; t0 = cyc;
    @(negedge clk); start8 = 1'b0;
    repeat (2) @(negedge clk);
    start8 = 1'b1; sm8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    wait_done8(t1, gaps);
    check("ignored_start_lat", t1 - t0, 10);
    check("ignored_start_y", y8, 16'h03A8);
    wait_done8(t2, gaps);
    @(negedge clk); start8 = 1'b0;
    check("b2b_gap", t2 - t1, 11);
    check("b2b_y", y8, 16'h0001);
    check("b2b_busy_gap", gaps, 0);

    // Asynchronous reset in the middle of a run.
    @(negedge clk); sm8 = 1'b1; a8 = 8'h55; b8 = 8'h66; start8 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk); #3; rst8 = 1'b0;
    #1;
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_valid", valid8, 0);
    check("abort_y", y8, 0);
    @(negedge clk); rst8 = 1'b1;
    op8(1'b1, 8'h7B, 8'hC3, y, lat);
    check("post_abort_y", y, 64'(ref_mul(8, 1'b1, 8'h7B, 8'hC3)));
    check("post_abort_lat", lat, 10);

    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      op8(rs, ra, rb, y, lat);
      check("rand8_y", y, 64'(ref_mul(8, rs, longint'(ra), longint'(rb))));
      check("rand8_lat", lat, 10);
    end

    op4(1'b1, 4'h8, 4'h7, yy, lat);
    check("n4_m8x7_y", yy, 8'hC8);
    check("n4_m8x7_lat", lat, 6);
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          op4(s[0], a[3:0], b[3:0], yy, lat);
          check("n4_exh_y", yy, 64'(ref_mul(4, s[0], longint'(a), longint'(b))));
          check("n4_exh_lat", lat, 6);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
Parametrised sequential radix-2 Booth multiplier. It is the next-generation replacement for the fixed 8-bit multiplier in the keypad-calculator datapath.
- Operand width set by parameter; signed or unsigned mode selected per operation.
- Explicit start/busy/done/valid handshake.
- Sits between number storage (operands) and the binary-to-BCD/display path (result).

Parameters:
N, 8, operand width in bits (N >= 2); result width is 2N
CNT_W, $clog2(N+2), iteration counter width (derived; not overridden)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with operands
A  input  N  multiplicand; captured on accepted start
B  input  N  multiplier; captured on accepted start
busy  output  1  high from the accepted start until the cycle done is asserted (exclusive)
done  output  1  one-cycle pulse when Y is updated
valid  output  1  high from done until next accepted start; Y meaningful while high
Y  output  2N  product; signed or unsigned per captured mode

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, busy=0, done=0, valid=0, Y=0, internal registers and counter=0. Reset mid-operation aborts the operation; there is no partial result.
- Internal width W=N+1. Operands are extended to W bits: sign-extended if signed_mode=1, zero-extended if 0. This gives uniform Booth handling for unsigned inputs.
- States:
  - IDLE
    - start=1 at edge k: capture extended A into M, extended B into Q, set accumulator ACC=0, Q_-1=0, counter=0.
    - Go to RUN; busy=1 and valid=0 from edge k.
    - start=0: remain in IDLE.
  - RUN: one Booth step per cycle.
    - Recode {Q[0],Q_-1}: 01 -> ACC=ACC+M; 10 -> ACC=ACC-M; 00/11 -> no add.
    - Then arithmetic right shift of {ACC,Q,Q_-1} by one; ACC MSB is replicated.
    - Counter increments. After W=N+1 steps (edges k+1..k+N+1), go to DONE.
  - DONE: entered at edge k+N+2. On that edge:
    - Y = lower 2N bits of {ACC,Q}.
    - done=1, valid=1, busy=0.
    - Next edge returns to IDLE with done=0.
- Latency is fixed at N+2 cycles from the start edge to done, independent of operand values.
- Width rules:
  - ACC is W bits; add/sub computed in W+1 bits to avoid overflow before the shift.
  - Product of two W-bit values always fits in 2N bits: signed range [-2^(2N-2)+2^(N-1), 2^(2N-2)], unsigned max (2^N-1)^2.
- start while busy or in DONE: ignored, no effect on the running operation. A and B may change freely after capture.
- Back-to-back: start held high continuously begins the next operation on the first IDLE cycle after DONE. Sustained throughput is one result per N+3 cycles.
- Y holds its last value through subsequent operations until the next done. valid drops on the accepted start edge.
- signed_mode changes after capture have no effect.

Test Plan:
- N=8, signed_mode=1, A=3, B=-5 (0xFB), start pulse -> done exactly 10 cycles later; Y=0xFFF1 (-15); valid=1 thereafter; busy high for cycles 0..9.
- N=8, signed_mode=0, A=0xFF, B=0xFF -> Y=0xFE01 (65025). Same operands with signed_mode=1 -> Y=0x0001.
- N=8, signed_mode=1, A=0x80, B=0x80 (-128*-128) -> Y=0x4000. A=0x80, B=0x7F -> Y=0xC080 (-16256).
- Start re-asserted and A/B changed during RUN -> ignored; Y equals product of the originally captured operands. With start held high: second done exactly 11 cycles after the first.
- rst driven low mid-RUN (cycle 4) -> busy, done, valid, Y go to 0 immediately without waiting for clk. After release, a new start completes normally with correct product.
- Parameter sweep N=4, signed_mode=1, A=-8 (0x8), B=7 -> Y=0xC8 (-56), latency 6 cycles. Exhaustive random check of all 256 signed and 256 unsigned pairs at N=4 against a reference model.
